base64_serializer: RTL and testbench

BASE64_SERIALIZER -- requirements
Module: base64_serializer

---
 rtl/base64_pkg.sv | 32 +++
 rtl/base64_pad_calc.sv | 24 ++
 rtl/base64_serializer.sv | 139 +++++++++++++
 tb/tb_base64_serializer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/base64_pkg.sv
// Shared constants, FSM state type and character-selection helper for the
// base64 line serializer.
package base64_pkg;

  localparam logic [7:0] CHAR_PAD    = 8'h3D;
  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;
  localparam int         BLOCK_BYTES = 60;
  localparam int         BLOCK_CHARS = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } state_t;

  // Character i of a block, with the trailing pad positions forced to '='.
  // Char 0 lives in the top byte of the block word.
  function automatic logic [7:0] char_at(input logic [BLOCK_CHARS*8-1:0] d,
                                         input logic [6:0]               i,
                                         input logic [6:0]               nch,
                                         input logic [1:0]               pad);
    logic [9:0] lsb;
    lsb = 10'(BLOCK_CHARS*8 - 8) - {i, 3'b000};
    if (i >= (nch - {5'b00000, pad})) begin
      return CHAR_PAD;
    end
    return d[lsb +: 8];
  endfunction

endpackage

// File: rtl/base64_pad_calc.sv
// Maps a raw byte count to the number of encoded characters to emit and the
// number of trailing pad characters. Out-of-range counts mean a full block.
module base64_pad_calc
  import base64_pkg::*;
(
  input  logic [6:0] len,
  output logic [6:0] nch,
  output logic [1:0] pad
);

  logic [6:0] n;
  logic [6:0] groups;
  logic [1:0] rem;

  // Saturate the length, then round up to whole 3-byte groups.
  always_comb begin
    n      = ((len == 7'd0) || (len > 7'(BLOCK_BYTES))) ? 7'(BLOCK_BYTES) : len;
    rem    = 2'(n % 7'd3);
    groups = (n + 7'd2) / 7'd3;
    nch    = groups << 2;
    pad    = (rem == 2'd0) ? 2'd0 : (2'd3 - rem);
  end

endmodule

// File: rtl/base64_serializer.sv
// Serializes 80-character base64 blocks into a byte stream, replacing the
// unused tail with '=' pads and inserting CR LF every LINE_LEN characters and
// at the end of each message. The line count carries across the blocks of a
// message, so line breaks land at the same place regardless of block size.
module base64_serializer
  import base64_pkg::*;
#(
  parameter int LINE_LEN = 76,
  parameter int CRLF_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [BLOCK_CHARS*8-1:0] blk_data,
  input  logic [6:0]               blk_len,
  input  logic                     blk_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last
);

  localparam int LC_W = $clog2(LINE_LEN + 1);

  state_t                   state;
  logic [BLOCK_CHARS*8-1:0] data_r;
  logic [6:0]               nch_r;
  logic [1:0]               pad_r;
  logic                     last_r;
  logic [6:0]               idx;
  logic [LC_W-1:0]          line_cnt;

  logic [6:0]      acc_nch;
  logic [1:0]      acc_pad;
  logic            accept;
  logic            fire;
  logic [6:0]      idx_nx;
  logic [LC_W-1:0] lc_nx;
  logic            at_last_char;
  logic            line_full;
  logic            msg_end;

  base64_pad_calc u_pad_calc (
    .len (blk_len),
    .nch (acc_nch),
    .pad (acc_pad)
  );

  assign accept       = blk_valid && blk_ready;
  assign fire         = out_valid && out_ready;
  assign idx_nx       = idx + 7'd1;
  assign lc_nx        = (CRLF_EN != 0) ? (line_cnt + 1'b1) : '0;
  assign at_last_char = (idx_nx == nch_r);
  assign line_full    = (lc_nx == LC_W'(LINE_LEN));
  assign msg_end      = at_last_char && last_r;

  // Block payload is only read while a block is in flight, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_r <= blk_data;
      nch_r  <= acc_nch;
      pad_r  <= acc_pad;
    end
  end

  // Control FSM with registered handshake and output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      idx       <= 7'd0;
      line_cnt  <= '0;
      last_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= CHAR;
            blk_ready <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= char_at(blk_data, 7'd0, acc_nch, acc_pad);
            out_last  <= 1'b0;
            idx       <= 7'd0;
            last_r    <= blk_last;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        CHAR: begin
          if (fire) begin
            idx      <= idx_nx;
            line_cnt <= lc_nx;
            if ((CRLF_EN != 0) && (line_full || msg_end)) begin
              // One CR LF covers both a full line and the message end.
              state    <= CR;
              out_data <= CHAR_CR;
              out_last <= 1'b0;
            end else if (at_last_char) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              blk_ready <= 1'b1;
            end else begin
              out_data <= char_at(data_r, idx_nx, nch_r, pad_r);
              out_last <= (CRLF_EN == 0) && last_r && (idx_nx == (nch_r - 7'd1));
            end
          end
        end
        CR: begin
          if (fire) begin
            state    <= LF;
            out_data <= CHAR_LF;
            out_last <= last_r && (idx == nch_r);
          end
        end
        LF: begin
          if (fire) begin
            line_cnt <= '0;
            out_last <= 1'b0;
            if (idx != nch_r) begin
              state    <= CHAR;
              out_data <= char_at(data_r, idx, nch_r, pad_r);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              blk_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_base64_serializer.sv
// Randomized scoreboard bench for base64_serializer (LINE_LEN=76, CRLF_EN=1).
module tb_base64_serializer;

  localparam int LINE = 76;

  logic         clk;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [639:0] blk_data;
  logic [6:0]   blk_len;
  logic         blk_last;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;

  base64_serializer #(.LINE_LEN(LINE), .CRLF_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_len   (blk_len),
    .blk_last  (blk_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int         checks = 0;
  int         passes = 0;
  int         pops   = 0;
  int         lc_model = 0;
  bit         rand_ready = 0;
  logic [8:0] q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: expected byte stream of one block, from the encoding rules.
  function automatic void push_expected(input logic [639:0] d, input int len, input bit last);
    int n, nch, pad;
    logic [7:0] b;
    n   = (len == 0 || len > 60) ? 60 : len;
    nch = 4 * ((n + 2) / 3);
    pad = (3 - (n % 3)) % 3;
    for (int i = 0; i < nch; i++) begin
      b = (i >= nch - pad) ? 8'h3D : d[639 - 8*i -: 8];
      q.push_back({1'b0, b});
      lc_model++;
      if (lc_model == LINE || (last && i == nch - 1)) begin
        q.push_back({1'b0, 8'h0D});
        q.push_back({last && (i == nch - 1), 8'h0A});
        lc_model = 0;
      end
    end
  endfunction

  function automatic logic [639:0] rand_chars();
    logic [639:0] d;
    for (int i = 0; i < 80; i++) d[639 - 8*i -: 8] = 8'($urandom_range(33, 126));
    return d;
  endfunction

  // Monitor: compares every accepted byte and checks stability under stall.
  initial begin
    logic [7:0] prev_d;
    logic       prev_l;
    bit         stall_prev;
    logic [8:0] exp;
    stall_prev = 0;
    prev_d = 0;
    prev_l = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (stall_prev)
          check("stall_hold", out_valid && out_data == prev_d && out_last == prev_l,
                {out_valid, out_last, out_data}, {1'b1, prev_l, prev_d});
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_byte", 0, {out_last, out_data}, 0);
          end else begin
            exp = q.pop_front();
            check("byte", {out_last, out_data} == exp, {out_last, out_data}, exp);
          end
          pops++;
        end
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
  end

  // Sink readiness: always ready or a 50% random pattern.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_block(input logic [639:0] d, input int len, input bit last);
    bit got = 0;
    @(posedge clk);
    #1;
    blk_valid = 1;
    blk_data  = d;
    blk_len   = 7'(len);
    blk_last  = last;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (blk_ready) begin got = 1; break; end
    end
    if (!got) begin
      check("accept_timeout", 0, 0, 1);
      blk_valid = 0;
      return;
    end
    push_expected(d, len, last);
    @(posedge clk);
    #1 blk_valid = 0;
    @(negedge clk);
    check("latency_valid", out_valid == 1'b1, out_valid, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (q.size() == 0 && blk_ready) begin done = 1; break; end
    end
    check("drain", done && q.size() == 0, q.size(), 0);
  endtask

  initial begin
    logic [639:0] d;
    int base;
    bit ok;
    rst = 1; blk_valid = 0; blk_data = '0; blk_len = '0; blk_last = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid == 0, out_valid, 0);
      check("rst_blk_ready", blk_ready == 0, blk_ready, 0);
      check("rst_out_data", out_data == 0, out_data, 0);
      check("rst_out_last", out_last == 0, out_last, 0);
    end
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", blk_ready == 1, blk_ready, 1);

    // "TWFu", 3 bytes
    d = '0; d[639:608] = "TWFu";
    send_block(d, 3, 1);
    drain();

    // "TQ==", 1 byte, tail garbage must be discarded
    d = rand_chars(); d[639:608] = "TQAA";
    send_block(d, 1, 1);
    drain();

    // Two full blocks: breaks after 76, 152 and 160
    send_block(rand_chars(), 60, 0);
    send_block(rand_chars(), 60, 1);
    drain();

    // Same with random backpressure
    rand_ready = 1;
    send_block(rand_chars(), 60, 0);
    send_block(rand_chars(), 60, 1);
    drain();
    rand_ready = 0;

    // Exactly one full line at message end
    send_block(rand_chars(), 57, 1);
    drain();

    // Random messages, including saturating lengths 0 and >60
    rand_ready = 1;
    for (int m = 0; m < 6; m++) begin
      int nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++)
        send_block(rand_chars(), $urandom_range(0, 127), b == nb - 1);
    end
    send_block(rand_chars(), 0, 1);
    send_block(rand_chars(), 100, 1);
    drain();
    rand_ready = 0;

    // Reset in the middle of a block
    base = pops;
    send_block(rand_chars(), 60, 0);
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      if (pops - base >= 10) begin ok = 1; break; end
      @(negedge clk);
    end
    check("mid_wait", ok, pops - base, 10);
    @(posedge clk);
    #1 rst = 1;
    #1;
    check("mid_rst_valid", out_valid == 0, out_valid, 0);
    check("mid_rst_ready", blk_ready == 0, blk_ready, 0);
    q.delete();
    lc_model = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_ready_after", blk_ready == 1, blk_ready, 1);
    check("mid_valid_after", out_valid == 0, out_valid, 0);

    // Fresh message must start a new line count
    send_block(rand_chars(), 57, 1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
